// File: rtl/bcd_entry_ctrl_if.sv
// rtl/bcd_entry_ctrl_if.sv - operator digit/button inputs and validated count outputs
interface bcd_entry_ctrl_if;
  logic [3:0] digitIn;
  logic       enterKey;
  logic       clearKey;
  logic [3:0] highBCD;
  logic [3:0] lowBCD;
  logic       readyToInput;
  logic       entryErr;
  logic [1:0] entryStage;

  modport master (
    output digitIn, enterKey, clearKey,
    input  highBCD, lowBCD, readyToInput, entryErr, entryStage
  );

  modport slave (
    input  digitIn, enterKey, clearKey,
    output highBCD, lowBCD, readyToInput, entryErr, entryStage
  );
endinterface

// File: rtl/bcd_entry_ctrl.sv
// rtl/bcd_entry_ctrl.sv - debounced two-digit BCD entry with range check and lock
module bcd_entry_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_WIDTH  = 20,
  parameter int MAX_TABS  = 50
) (
  input  logic            origCP,
  input  logic            reset,
  bcd_entry_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    WAIT_LOW  = 2'd1,
    CHECK     = 2'd2,
    LOCKED    = 2'd3
  } state_e;

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);
  localparam logic [6:0]          MAX_V   = 7'(MAX_TABS);

  logic [3:0]          dig_s1_q, dig_s2_q;
  logic [1:0]          key_raw;
  logic [1:0]          key_s1_q, key_s2_q;
  logic [1:0]          db_q, db_prev_q, press_q;
  logic [DB_WIDTH-1:0] cnt_q [2];
  logic                enter_p, clear_p;

  // Bit 0 is the enter key, bit 1 the clear key.
  assign key_raw = {bus.clearKey, bus.enterKey};
  assign enter_p = press_q[0];
  assign clear_p = press_q[1];

  // The counter measures how long the synchronised level has disagreed with
  // the debounced level; any return to agreement restarts it.
  always_ff @(posedge origCP or negedge reset) begin
    if (!reset) begin
      dig_s1_q  <= '0;
      dig_s2_q  <= '0;
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      dig_s1_q  <= bus.digitIn;
      dig_s2_q  <= dig_s1_q;
      key_s1_q  <= key_raw;
      key_s2_q  <= key_s1_q;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (key_s2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          db_q[i]  <= key_s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_e     state_q, state_d;
  logic [3:0] high_q, high_d, low_q, low_d;
  logic       ready_q, ready_d, err_q, err_d;
  logic [6:0] value;

  assign value = {3'b000, high_q} * 7'd10 + {3'b000, low_q};

  always_ff @(posedge origCP or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_HIGH;
      high_q  <= '0;
      low_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    ready_d = ready_q;
    err_d   = err_q;
    if (clear_p) begin
      state_d = WAIT_HIGH;
      high_d  = '0;
      low_d   = '0;
      ready_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT_HIGH: if (enter_p) begin
          if (dig_s2_q > 4'd9) begin
            err_d = 1'b1;
          end else begin
            high_d  = dig_s2_q;
            err_d   = 1'b0;
            state_d = WAIT_LOW;
          end
        end
        WAIT_LOW: if (enter_p) begin
          if (dig_s2_q > 4'd9) begin
            err_d = 1'b1;
          end else begin
            low_d   = dig_s2_q;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (value == 7'd0 || value > MAX_V) begin
            err_d   = 1'b1;
            high_d  = '0;
            low_d   = '0;
            state_d = WAIT_HIGH;
          end else begin
            ready_d = 1'b1;
            state_d = LOCKED;
          end
        end
        LOCKED: ;
        default: state_d = WAIT_HIGH;
      endcase
    end
  end

  assign bus.highBCD      = high_q;
  assign bus.lowBCD       = low_q;
  assign bus.readyToInput = ready_q;
  assign bus.entryErr     = err_q;
  assign bus.entryStage   = state_q;

endmodule
